// File: rtl/keyboard_move_pkg.sv
// Scancode constants, FSM/key encodings and set-2 lookup helpers shared by the
// keyboard move-entry block.
package keyboard_move_pkg;

  localparam logic [3:0] NONE     = 4'hF;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {WAIT_LETTER, WAIT_NUMBER, READY, COMMIT} state_t;
  typedef enum logic [2:0] {K_NONE, K_LETTER, K_DIGIT, K_ENTER, K_BKSP, K_ESC} key_kind_t;

  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] val;
  } key_ev_t;

  function automatic logic [3:0] letter_of(input logic [7:0] sc);
    case (sc)
      8'h1C: return 4'd0;
      8'h32: return 4'd1;
      8'h21: return 4'd2;
      8'h23: return 4'd3;
      8'h24: return 4'd4;
      8'h2B: return 4'd5;
      8'h34: return 4'd6;
      8'h33: return 4'd7;
      8'h43: return 4'd8;
      8'h3B: return 4'd9;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [3:0] digit_of(input logic [7:0] sc);
    case (sc)
      8'h45: return 4'd0;
      8'h16: return 4'd1;
      8'h1E: return 4'd2;
      8'h26: return 4'd3;
      8'h25: return 4'd4;
      8'h2E: return 4'd5;
      8'h36: return 4'd6;
      8'h3D: return 4'd7;
      8'h3E: return 4'd8;
      8'h46: return 4'd9;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/keyboard_move_entry_if.sv
// PS/2 lines in, display/game-logic signals out of the move-entry block.
interface keyboard_move_entry_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] letter;
  logic [3:0] number;
  logic       playerTurn;
  logic       keyboardData;
  logic       move_valid;
  logic       frame_error;

  modport master (
    input  ps2_clk, ps2_data,
    output letter, number, playerTurn, keyboardData, move_valid, frame_error
  );
  modport slave (
    output ps2_clk, ps2_data,
    input  letter, number, playerTurn, keyboardData, move_valid, frame_error
  );
endinterface

// File: rtl/keyboard_move_entry_rx.sv
// PS/2 frame receiver: synchronisers, ps2_clk glitch filter, 11-bit frame
// assembly with start/parity/stop checks and a partial-frame timeout.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_error
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s, clk_f, fall;
  logic [FW-1:0]          flt_cnt;
  logic [3:0]             bit_cnt;
  logic [8:0]             shreg;
  logic [TW-1:0]          tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign fall = clk_f && !clk_s && (flt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == clk_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_f   <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // bit_cnt: 0 = idle/expect start, 1..9 = data+parity, 10 = stop.
  always_ff @(posedge clk) begin
    byte_valid <= 1'b0;
    byte_error <= 1'b0;
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_data <= '0;
      tmo       <= '0;
    end else if (fall) begin
      tmo <= '0;
      if (bit_cnt == 4'd0) begin
        if (!dat_s) bit_cnt <= 4'd1;
        else        byte_error <= 1'b1;
      end else if (bit_cnt < 4'd10) begin
        shreg   <= {dat_s, shreg[8:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
        if (dat_s && ^shreg) begin
          byte_data  <= shreg[7:0];
          byte_valid <= 1'b1;
        end else begin
          byte_error <= 1'b1;
        end
      end
    end else if (bit_cnt != 4'd0) begin
      if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt    <= '0;
        tmo        <= '0;
        byte_error <= 1'b1;
      end else begin
        tmo <= tmo + 1'b1;
      end
    end else begin
      tmo <= '0;
    end
  end

endmodule

// File: rtl/keyboard_move_entry.sv
// Keyboard move entry: decodes set-2 make codes from the PS/2 receiver and runs
// the letter/number/Enter entry FSM that feeds the display and game logic.
module keyboard_move_entry
  import keyboard_move_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input logic                   clock27,
  input logic                   reset,
  keyboard_move_entry_if.master kb
);
  logic [7:0] byte_data;
  logic       byte_valid, byte_error;
  logic       brk, ext;
  key_ev_t    key;
  state_t     state;
  logic [3:0] letter, number;
  logic       turn, kd, mv, fe;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clock27),
    .rst       (reset),
    .ps2_clk   (kb.ps2_clk),
    .ps2_data  (kb.ps2_data),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_error(byte_error)
  );

  // Prefix flags apply to exactly the next non-prefix byte.
  always_ff @(posedge clock27) begin
    if (reset) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == SC_BREAK)    brk <= 1'b1;
      else if (byte_data == SC_EXT) ext <= 1'b1;
      else begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

  always_comb begin
    key.kind = K_NONE;
    key.val  = NONE;
    if (byte_valid && !brk && byte_data != SC_BREAK && byte_data != SC_EXT) begin
      if (ext) begin
        if (byte_data == SC_ENTER) key.kind = K_ENTER;
      end else if (letter_of(byte_data) != NONE) begin
        key.kind = K_LETTER;
        key.val  = letter_of(byte_data);
      end else if (digit_of(byte_data) != NONE) begin
        key.kind = K_DIGIT;
        key.val  = digit_of(byte_data);
      end else if (byte_data == SC_ENTER) key.kind = K_ENTER;
      else if (byte_data == SC_BKSP)      key.kind = K_BKSP;
      else if (byte_data == SC_ESC)       key.kind = K_ESC;
    end
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      state  <= WAIT_LETTER;
      letter <= NONE;
      number <= NONE;
      turn   <= 1'b0;
      kd     <= 1'b0;
      mv     <= 1'b0;
      fe     <= 1'b0;
    end else begin
      kd <= (key.kind != K_NONE);
      mv <= 1'b0;
      fe <= byte_error;
      // COMMIT runs the cycle after move_valid so game logic sees the held move.
      if (state == COMMIT) begin
        letter <= NONE;
        number <= NONE;
        turn   <= ~turn;
        state  <= WAIT_LETTER;
      end else if (key.kind == K_ESC) begin
        letter <= NONE;
        number <= NONE;
        state  <= WAIT_LETTER;
      end else begin
        case (state)
          WAIT_LETTER: begin
            if (key.kind == K_LETTER) begin
              letter <= key.val;
              state  <= WAIT_NUMBER;
            end
          end
          WAIT_NUMBER: begin
            if (key.kind == K_LETTER) letter <= key.val;
            else if (key.kind == K_DIGIT) begin
              number <= key.val;
              state  <= READY;
            end else if (key.kind == K_BKSP) begin
              letter <= NONE;
              state  <= WAIT_LETTER;
            end
          end
          READY: begin
            if (key.kind == K_ENTER) begin
              mv    <= 1'b1;
              state <= COMMIT;
            end else if (key.kind == K_DIGIT)  number <= key.val;
            else if (key.kind == K_LETTER)     letter <= key.val;
            else if (key.kind == K_BKSP) begin
              number <= NONE;
              state  <= WAIT_NUMBER;
            end
          end
          default: state <= WAIT_LETTER;
        endcase
      end
    end
  end

  assign kb.letter       = letter;
  assign kb.number       = number;
  assign kb.playerTurn   = turn;
  assign kb.keyboardData = kd;
  assign kb.move_valid   = mv;
  assign kb.frame_error  = fe;

endmodule

// File: tb/tb_keyboard_move_entry.sv
// Scoreboard bench for keyboard_move_entry: PS/2 frames in, expected strobe
// events queued per frame and matched against each observed strobe cycle.
module tb_keyboard_move_entry;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keyboard_move_entry_if kb ();

  keyboard_move_entry #(
    .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(27000)
  ) dut (
    .clock27(clk),
    .reset  (rst),
    .kb     (kb.master)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {kd, mv, fe, turn, letter, number}
  function automatic logic [31:0] ev(input bit kd, input bit mv, input bit fe, input bit turn,
                                     input logic [3:0] l, input logic [3:0] n);
    return {20'b0, kd, mv, fe, turn, l, n};
  endfunction

  always @(negedge clk) begin
    if (!rst && (kb.keyboardData || kb.move_valid || kb.frame_error)) begin
      logic [31:0] got;
      got = ev(kb.keyboardData, kb.move_valid, kb.frame_error, kb.playerTurn, kb.letter, kb.number);
      if (exp_q.size() == 0) chk("unexpected_event", got, 32'h0);
      else                   chk("event", got, exp_q.pop_front());
    end
  end

  task automatic frame(input logic [7:0] b, input bit bad_par = 1'b0,
                       input int nbits = 11, input bit glitch = 1'b0);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb.ps2_data = f[i];
      if (glitch && i == 4) begin
        repeat (HALF/2) @(posedge clk);
        kb.ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        kb.ps2_clk = 1'b1;
        repeat (HALF/2 - 3) @(posedge clk);
      end else repeat (HALF) @(posedge clk);
      kb.ps2_clk = 1'b0;
      if (glitch && i == 6) begin
        repeat (HALF/2) @(posedge clk);
        kb.ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
        kb.ps2_clk = 1'b0;
        repeat (HALF/2 - 4) @(posedge clk);
      end else repeat (HALF) @(posedge clk);
      kb.ps2_clk = 1'b1;
    end
    kb.ps2_data = 1'b1;
    repeat (4*HALF) @(posedge clk);
  endtask

  task automatic key(input logic [7:0] b, input logic [31:0] e);
    exp_q.push_back(e);
    frame(b);
  endtask

  task automatic check_state(input string tag, input logic [3:0] l, input logic [3:0] n, input bit t);
    @(negedge clk);
    chk({tag, "_letter"}, kb.letter, l);
    chk({tag, "_number"}, kb.number, n);
    chk({tag, "_turn"}, kb.playerTurn, t);
  endtask

  initial begin
    kb.ps2_clk  = 1'b1;
    kb.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    check_state("reset", 4'hF, 4'hF, 1'b0);
    chk("reset_strobes", {kb.keyboardData, kb.move_valid, kb.frame_error}, 3'b000);

    // Basic move and commit
    key(8'h1C, ev(1, 0, 0, 0, 4'd0, 4'hF));
    key(8'h16, ev(1, 0, 0, 0, 4'd0, 4'd1));
    key(8'h5A, ev(1, 1, 0, 0, 4'd0, 4'd1));
    check_state("commit", 4'hF, 4'hF, 1'b1);

    // Break code ignored; Enter ignored in WAIT_NUMBER; Backspace clears letter
    key(8'h1C, ev(1, 0, 0, 1, 4'd0, 4'hF));
    frame(8'hF0);
    frame(8'h1C);
    key(8'h32, ev(1, 0, 0, 1, 4'd1, 4'hF));
    key(8'h5A, ev(1, 0, 0, 1, 4'd1, 4'hF));
    key(8'h66, ev(1, 0, 0, 1, 4'hF, 4'hF));

    // Bad parity
    exp_q.push_back(ev(0, 0, 1, 1, 4'hF, 4'hF));
    frame(8'h1C, 1'b1);
    check_state("parity", 4'hF, 4'hF, 1'b1);

    // Partial frame timeout, then a good frame
    exp_q.push_back(ev(0, 0, 1, 1, 4'hF, 4'hF));
    frame(8'h24, 1'b0, 5);
    repeat (27100) @(posedge clk);
    key(8'h24, ev(1, 0, 0, 1, 4'd4, 4'hF));

    // Backspace chain and Esc
    key(8'h3B, ev(1, 0, 0, 1, 4'd9, 4'hF));
    key(8'h46, ev(1, 0, 0, 1, 4'd9, 4'd9));
    key(8'h66, ev(1, 0, 0, 1, 4'd9, 4'hF));
    key(8'h66, ev(1, 0, 0, 1, 4'hF, 4'hF));
    key(8'h76, ev(1, 0, 0, 1, 4'hF, 4'hF));
    check_state("esc", 4'hF, 4'hF, 1'b1);

    // Reset with a pending break flag and a partial frame
    key(8'h2B, ev(1, 0, 0, 1, 4'd5, 4'hF));
    frame(8'hF0);
    frame(8'h1C, 1'b0, 5);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    check_state("midreset", 4'hF, 4'hF, 1'b0);
    key(8'h1C, ev(1, 0, 0, 0, 4'd0, 4'hF));

    // Glitched ps2_clk mid-frame
    exp_q.push_back(ev(1, 0, 0, 0, 4'd0, 4'd0));
    frame(8'h45, 1'b0, 11, 1'b1);

    // Extended codes: only E0 5A accepted; unknown code ignored
    frame(8'hE0);
    frame(8'h32);
    frame(8'h15);
    frame(8'hE0);
    key(8'h5A, ev(1, 1, 0, 0, 4'd0, 4'd0));
    check_state("kp_enter", 4'hF, 4'hF, 1'b1);

    repeat (20) @(posedge clk);
    chk("drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
